// File: rtl/hangman_pkg.sv
// Shared encodings and parameter-legality helpers for the hangman game core.
//   game_state_t  : FSM encodings, also the value driven on game_state
//   result_code_t : per-guess result codes driven on result_code
//   lw_ok / ww_ok : elaboration-time width checks used by the top
package hangman_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_PLAY = 3'd2,
      ST_WON  = 3'd3,
      ST_LOST = 3'd4,
      ST_DONE = 3'd5
   } game_state_t;

   typedef enum logic [1:0] {
      RES_HIT     = 2'd0,
      RES_MISS    = 2'd1,
      RES_REPEAT  = 2'd2,
      RES_INVALID = 2'd3
   } result_code_t;

   // Letter index must be able to address every letter of the alphabet.
   function automatic bit lw_ok(input int alpha, input int lw);
      return (2 ** lw) >= alpha;
   endfunction

   // Wrong counter must be able to hold MAX_WRONG itself.
   function automatic bit ww_ok(input int max_wrong, input int ww);
      return (2 ** ww) > max_wrong;
   endfunction

endpackage

// File: rtl/hangman_game_core_if.sv
// Guess/result handshake between the guess source (keyboard side) and the core.
//   guess_valid/guess_letter : guess strobe and letter index (master -> core)
//   guess_ready              : core accepts guesses (core -> master)
//   result_valid/result_code : one-cycle result pulse and held code (core -> master)
interface hangman_game_core_if #(parameter int LW = 5);
   logic          guess_valid;
   logic [LW-1:0] guess_letter;
   logic          guess_ready;
   logic          result_valid;
   logic [1:0]    result_code;

   modport master (output guess_valid, guess_letter,
                   input  guess_ready, result_valid, result_code);
   modport slave  (input  guess_valid, guess_letter,
                   output guess_ready, result_valid, result_code);
endinterface

// File: rtl/hangman_game_core_guess_timer.sv
// Per-guess timeout counter.
//   clk, resetn : clock, async active-low reset (clears the count)
//   reload      : load TIMEOUT (LOAD entry, accepted guess, expiry)
//   enable      : count down while set (core is in PLAY)
//   expired     : high during the last idle cycle of the window
// With TIMEOUT=0 the timer does not exist and expired is tied low.
module guess_timer #(
   parameter int TIMEOUT = 0
) (
   input  logic clk,
   input  logic resetn,
   input  logic reload,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, resetn, reload, enable};
         assign expired   = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] count;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)                    count <= '0;
            else if (reload)                count <= CW'(TIMEOUT);
            else if (enable && count != '0) count <= count - 1'b1;
         end

         // Firing on count==1 makes expiry land exactly TIMEOUT enabled cycles after reload.
         assign expired = enable && (count == CW'(1));
      end
   endgenerate

endmodule

// File: rtl/hangman_game_core.sv
// Multi-round hangman controller.
//   clk, resetn   : clock, async active-low reset
//   start         : pulse; begins the first/next round, or restarts from DONE
//   target_mask   : letters present in the current word, sampled in LOAD
//   gif (slave)   : guess handshake and per-guess result pulse/code
//   guessed_mask  : letters guessed this round
//   wrong_count   : misses this round
//   game_state    : IDLE/LOAD/PLAY/WON/LOST/DONE
//   round_idx     : current round, also the word_ram address offset
//   score         : cumulative saturating score
module hangman_game_core
   import hangman_pkg::*;
#(
   parameter int ALPHA     = 26,
   parameter int LW        = 5,
   parameter int MAX_WRONG = 6,
   parameter int WW        = 4,
   parameter int ROUNDS    = 4,
   parameter int RW        = 2,
   parameter int SCORE_W   = 8,
   parameter int TIMEOUT   = 0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [ALPHA-1:0]   target_mask,
   hangman_game_core_if.slave gif,
   output logic [ALPHA-1:0]   guessed_mask,
   output logic [WW-1:0]      wrong_count,
   output logic [2:0]         game_state,
   output logic [RW-1:0]      round_idx,
   output logic [SCORE_W-1:0] score
);

   generate
      if (!lw_ok(ALPHA, LW))    begin : g_bad_lw $error("LW too narrow for ALPHA"); end
      if (!ww_ok(MAX_WRONG, WW)) begin : g_bad_ww $error("WW too narrow for MAX_WRONG"); end
   endgenerate

   localparam int SUMW = ((SCORE_W > WW) ? SCORE_W : WW) + 1;

   game_state_t        state;
   result_code_t       res_code, code_nxt;
   logic               res_valid;
   logic [ALPHA-1:0]   target, gbit;
   logic               accept, invalid, expired, won, lost, in_play;
   logic [WW-1:0]      win_misses;
   logic [SUMW-1:0]    sum;
   logic [SCORE_W-1:0] score_sat;

   assign in_play          = (state == ST_PLAY);
   assign gif.guess_ready  = in_play;
   assign gif.result_valid = res_valid;
   assign gif.result_code  = res_code;
   assign game_state       = state;

   assign accept  = gif.guess_valid && in_play;
   assign invalid = 32'(gif.guess_letter) >= 32'(ALPHA);
   assign gbit    = invalid ? '0 : (ALPHA'(1) << gif.guess_letter);
   assign won     = (guessed_mask & target) == target;
   assign lost    = (wrong_count == WW'(MAX_WRONG));

   always_comb begin
      code_nxt = RES_MISS;
      if (invalid)                     code_nxt = RES_INVALID;
      else if (|(guessed_mask & gbit)) code_nxt = RES_REPEAT;
      else if (|(target & gbit))       code_nxt = RES_HIT;
   end

   // A zero-target word wins straight out of LOAD, before wrong_count has been cleared.
   assign win_misses = (state == ST_LOAD) ? '0 : wrong_count;
   assign sum        = SUMW'(score) + SUMW'(WW'(MAX_WRONG) - win_misses);
   assign score_sat  = (|sum[SUMW-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];

   guess_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .resetn  (resetn),
      .reload  ((state == ST_LOAD) || accept || expired),
      .enable  (in_play),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         target       <= '0;
         guessed_mask <= '0;
         wrong_count  <= '0;
         round_idx    <= '0;
         score        <= '0;
         res_valid    <= 1'b0;
         res_code     <= RES_HIT;
      end else begin
         res_valid <= 1'b0;
         case (state)
            ST_IDLE: if (start) state <= ST_LOAD;
            ST_LOAD: begin
               target       <= target_mask;
               guessed_mask <= '0;
               wrong_count  <= '0;
               if (target_mask == '0) begin
                  state <= ST_WON;
                  score <= score_sat;
               end else begin
                  state <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               // The end-of-round decision looks at last cycle's update; a guess or
               // expiry arriving in the deciding cycle is dropped.
               if (won) begin
                  state <= ST_WON;
                  score <= score_sat;
               end else if (lost) begin
                  state <= ST_LOST;
               end else if (accept) begin
                  res_valid <= 1'b1;
                  res_code  <= code_nxt;
                  if (code_nxt == RES_HIT || code_nxt == RES_MISS)
                     guessed_mask <= guessed_mask | gbit;
                  if (code_nxt == RES_MISS)
                     wrong_count <= wrong_count + 1'b1;
               end else if (expired) begin
                  res_valid   <= 1'b1;
                  res_code    <= RES_MISS;
                  wrong_count <= wrong_count + 1'b1;
               end
            end
            ST_WON, ST_LOST: if (start) begin
               if (round_idx < RW'(ROUNDS - 1)) begin
                  round_idx <= round_idx + 1'b1;
                  state     <= ST_LOAD;
               end else begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: if (start) begin
               score     <= '0;
               round_idx <= '0;
               state     <= ST_LOAD;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hangman_game_core.sv
module tb_hangman_game_core;

   logic clk, resetn;

   // default-parameter instance (no timeout)
   logic        d_start;
   logic [25:0] d_target, d_mask;
   logic [3:0]  d_wrong;
   logic [2:0]  d_state;
   logic [1:0]  d_round;
   logic [7:0]  d_score;
   hangman_game_core_if #(.LW(5)) gd ();

   // timeout / short-game instance
   logic        c_start;
   logic [25:0] c_target, c_mask;
   logic [3:0]  c_wrong;
   logic [2:0]  c_state;
   logic [0:0]  c_round;
   logic [2:0]  c_score;
   hangman_game_core_if #(.LW(5)) gc ();

   hangman_game_core u_def (
      .clk(clk), .resetn(resetn), .start(d_start), .target_mask(d_target), .gif(gd),
      .guessed_mask(d_mask), .wrong_count(d_wrong), .game_state(d_state),
      .round_idx(d_round), .score(d_score)
   );

   hangman_game_core #(.TIMEOUT(10), .ROUNDS(2), .RW(1), .SCORE_W(3)) u_cfg (
      .clk(clk), .resetn(resetn), .start(c_start), .target_mask(c_target), .gif(gc),
      .guessed_mask(c_mask), .wrong_count(c_wrong), .game_state(c_state),
      .round_idx(c_round), .score(c_score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic d_guess(input logic [4:0] l);
      gd.guess_valid  = 1'b1;
      gd.guess_letter = l;
      tick();
      gd.guess_valid = 1'b0;
   endtask

   task automatic c_guess(input logic [4:0] l);
      gc.guess_valid  = 1'b1;
      gc.guess_letter = l;
      tick();
      gc.guess_valid = 1'b0;
   endtask

   task automatic c_pulse(input logic [25:0] t);
      c_target = t;
      c_start  = 1'b1;
      tick();
      c_start = 1'b0;
   endtask

   localparam logic [1:0] OP_S = 2'd0;  // start pulse, then check after LOAD
   localparam logic [1:0] OP_G = 2'd1;  // guess, check result, then check end-of-round
   localparam logic [1:0] OP_N = 2'd2;  // guess while not ready, must be ignored

   typedef struct {
      logic [1:0]  op;
      logic [25:0] tgt;
      logic [4:0]  letter;
      logic [1:0]  code;
      logic [3:0]  wrong;
      logic [25:0] mask;
      logic [2:0]  st;
      logic [7:0]  sc;
      logic [1:0]  rnd;
   } vec_t;

   localparam int NV = 20;
   vec_t vt[NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            op    tgt      ltr    code  wr    mask      st    score  rnd
      vt[0]  = '{OP_S, 26'h3,  5'd0,  2'd0, 4'd0, 26'h0,  3'd2, 8'd0,  2'd0};
      vt[1]  = '{OP_G, 26'h0,  5'd0,  2'd0, 4'd0, 26'h1,  3'd2, 8'd0,  2'd0};
      vt[2]  = '{OP_G, 26'h0,  5'd1,  2'd0, 4'd0, 26'h3,  3'd3, 8'd6,  2'd0};
      vt[3]  = '{OP_S, 26'h4,  5'd0,  2'd0, 4'd0, 26'h0,  3'd2, 8'd6,  2'd1};
      vt[4]  = '{OP_G, 26'h0,  5'd0,  2'd1, 4'd1, 26'h1,  3'd2, 8'd6,  2'd1};
      vt[5]  = '{OP_G, 26'h0,  5'd1,  2'd1, 4'd2, 26'h3,  3'd2, 8'd6,  2'd1};
      vt[6]  = '{OP_G, 26'h0,  5'd3,  2'd1, 4'd3, 26'hB,  3'd2, 8'd6,  2'd1};
      vt[7]  = '{OP_G, 26'h0,  5'd4,  2'd1, 4'd4, 26'h1B, 3'd2, 8'd6,  2'd1};
      vt[8]  = '{OP_G, 26'h0,  5'd5,  2'd1, 4'd5, 26'h3B, 3'd2, 8'd6,  2'd1};
      vt[9]  = '{OP_G, 26'h0,  5'd6,  2'd1, 4'd6, 26'h7B, 3'd4, 8'd6,  2'd1};
      vt[10] = '{OP_N, 26'h0,  5'd2,  2'd0, 4'd6, 26'h7B, 3'd4, 8'd6,  2'd1};
      vt[11] = '{OP_S, 26'h3,  5'd0,  2'd0, 4'd0, 26'h0,  3'd2, 8'd6,  2'd2};
      vt[12] = '{OP_G, 26'h0,  5'd0,  2'd0, 4'd0, 26'h1,  3'd2, 8'd6,  2'd2};
      vt[13] = '{OP_G, 26'h0,  5'd0,  2'd2, 4'd0, 26'h1,  3'd2, 8'd6,  2'd2};
      vt[14] = '{OP_G, 26'h0,  5'd27, 2'd3, 4'd0, 26'h1,  3'd2, 8'd6,  2'd2};
      vt[15] = '{OP_G, 26'h0,  5'd2,  2'd1, 4'd1, 26'h5,  3'd2, 8'd6,  2'd2};
      vt[16] = '{OP_G, 26'h0,  5'd1,  2'd0, 4'd1, 26'h7,  3'd3, 8'd11, 2'd2};
      vt[17] = '{OP_S, 26'h0,  5'd0,  2'd0, 4'd0, 26'h0,  3'd3, 8'd17, 2'd3};
      vt[18] = '{OP_S, 26'h3,  5'd0,  2'd0, 4'd0, 26'h0,  3'd5, 8'd17, 2'd3};
      vt[19] = '{OP_S, 26'h3,  5'd0,  2'd0, 4'd0, 26'h0,  3'd2, 8'd0,  2'd0};

      resetn = 1'b0;
      d_start = 1'b0; d_target = '0; gd.guess_valid = 1'b0; gd.guess_letter = '0;
      c_start = 1'b0; c_target = '0; gc.guess_valid = 1'b0; gc.guess_letter = '0;
      repeat (3) tick();
      check("rst_state", 32'(d_state), 32'(0));
      check("rst_score", 32'(d_score), 32'(0));
      check("rst_ready", 32'(gd.guess_ready), 32'(0));
      check("rst_cfg_state", 32'(c_state), 32'(0));
      resetn = 1'b1;
      tick();

      // guess outside PLAY is ignored
      d_guess(5'd0);
      check("idle_guess_rv", 32'(gd.result_valid), 32'(0));
      check("idle_guess_st", 32'(d_state), 32'(0));

      for (int i = 0; i < NV; i++) begin
         case (vt[i].op)
            OP_S: begin
               d_target = vt[i].tgt;
               d_start  = 1'b1;
               tick();
               d_start = 1'b0;
               tick();
               check($sformatf("v%0d_state", i), 32'(d_state), 32'(vt[i].st));
               check($sformatf("v%0d_score", i), 32'(d_score), 32'(vt[i].sc));
               check($sformatf("v%0d_round", i), 32'(d_round), 32'(vt[i].rnd));
               check($sformatf("v%0d_wrong", i), 32'(d_wrong), 32'(vt[i].wrong));
               check($sformatf("v%0d_mask", i), 32'(d_mask), 32'(vt[i].mask));
            end
            OP_G: begin
               d_guess(vt[i].letter);
               check($sformatf("v%0d_rv", i), 32'(gd.result_valid), 32'(1));
               check($sformatf("v%0d_code", i), 32'(gd.result_code), 32'(vt[i].code));
               check($sformatf("v%0d_wrong", i), 32'(d_wrong), 32'(vt[i].wrong));
               check($sformatf("v%0d_mask", i), 32'(d_mask), 32'(vt[i].mask));
               tick();
               check($sformatf("v%0d_rv_low", i), 32'(gd.result_valid), 32'(0));
               check($sformatf("v%0d_state", i), 32'(d_state), 32'(vt[i].st));
               check($sformatf("v%0d_score", i), 32'(d_score), 32'(vt[i].sc));
               check($sformatf("v%0d_round", i), 32'(d_round), 32'(vt[i].rnd));
            end
            default: begin
               check($sformatf("v%0d_ready", i), 32'(gd.guess_ready), 32'(0));
               d_guess(vt[i].letter);
               check($sformatf("v%0d_rv", i), 32'(gd.result_valid), 32'(0));
               check($sformatf("v%0d_wrong", i), 32'(d_wrong), 32'(vt[i].wrong));
               check($sformatf("v%0d_mask", i), 32'(d_mask), 32'(vt[i].mask));
               check($sformatf("v%0d_state", i), 32'(d_state), 32'(vt[i].st));
            end
         endcase
      end

      // three misses, then asynchronous reset in the middle of a cycle
      d_guess(5'd2); tick();
      d_guess(5'd4); tick();
      d_guess(5'd5);
      check("pre_rst_code", 32'(gd.result_code), 32'(1));
      tick();
      check("pre_rst_wrong", 32'(d_wrong), 32'(3));
      #2 resetn = 1'b0;
      #1;
      check("arst_state", 32'(d_state), 32'(0));
      check("arst_wrong", 32'(d_wrong), 32'(0));
      check("arst_mask", 32'(d_mask), 32'(0));
      check("arst_code", 32'(gd.result_code), 32'(0));
      check("arst_ready", 32'(gd.guess_ready), 32'(0));
      tick();
      resetn = 1'b1;
      tick();

      // timeout: 10 idle PLAY cycles give a MISS
      c_pulse(26'h3);
      tick();
      check("to_state", 32'(c_state), 32'(2));
      repeat (9) tick();
      check("to_early_rv", 32'(gc.result_valid), 32'(0));
      check("to_early_wrong", 32'(c_wrong), 32'(0));
      tick();
      check("to_rv", 32'(gc.result_valid), 32'(1));
      check("to_code", 32'(gc.result_code), 32'(1));
      check("to_wrong", 32'(c_wrong), 32'(1));
      check("to_mask", 32'(c_mask), 32'(0));
      // guess in the exact expiry cycle wins over the timeout
      repeat (9) tick();
      check("to2_early_rv", 32'(gc.result_valid), 32'(0));
      c_guess(5'd0);
      check("to2_rv", 32'(gc.result_valid), 32'(1));
      check("to2_code", 32'(gc.result_code), 32'(0));
      check("to2_wrong", 32'(c_wrong), 32'(1));
      check("to2_mask", 32'(c_mask), 32'(1));
      tick();
      check("to2_no_extra_rv", 32'(gc.result_valid), 32'(0));
      check("to2_wrong_hold", 32'(c_wrong), 32'(1));

      // two clean rounds on a 3-bit score saturate at 7
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      for (int r = 0; r < 2; r++) begin
         c_pulse(26'h3);
         tick();
         c_guess(5'd0);
         c_guess(5'd1);
         tick();
         check($sformatf("sat_r%0d_state", r), 32'(c_state), 32'(3));
         check($sformatf("sat_r%0d_round", r), 32'(c_round), 32'(r));
      end
      check("sat_score", 32'(c_score), 32'(7));
      c_pulse(26'h3);
      tick();
      check("done_state", 32'(c_state), 32'(5));
      check("done_score", 32'(c_score), 32'(7));
      c_pulse(26'h3);
      check("restart_state", 32'(c_state), 32'(1));
      check("restart_score", 32'(c_score), 32'(0));
      check("restart_round", 32'(c_round), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
